// File: rtl/instr_loader.sv
// instr_loader
// Program loader for the fetch stage's instruction buffer. It takes a byte
// stream over a valid/ready handshake and packs each group of four bytes
// big-endian into a 32-bit instruction. Each word is written to consecutive
// buffer addresses starting at base_addr, and done pulses once the last word
// has been written. The fetch buffer only accepts writes while fetch is held
// in reset, so the top level keeps fetch in reset while busy is high.
//
// Ports
//   clk              rising-edge clock
//   rst              asynchronous reset, active low (0 = reset)
//   start            begin a load; only sampled while idle
//   abort            cancel the load in progress
//   base_addr        first buffer address, latched on start
//   word_count       number of words to load (clamped to 2**ADDR_W)
//   byte_in          stream byte (bit 0 = MSB)
//   byte_valid       byte_in is valid
//   byte_ready       loader accepts byte_in this cycle (receive state only)
//   load_en          buffer write strobe, one cycle per word
//   instr_load_addr  buffer write address (held between writes)
//   instruction_in   buffer write data (held between writes)
//   busy             a load is in progress (receive, write or done)
//   done             one-cycle pulse when all words are written
//   wrap_err         sticky: the address wrapped past the top during this load
module instr_loader #(
    parameter int ADDR_W = 10,
    parameter int CNT_W  = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [0:ADDR_W-1] base_addr,
    input  logic [0:CNT_W-1]  word_count,
    input  logic [0:7]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              load_en,
    output logic [0:ADDR_W-1] instr_load_addr,
    output logic [0:31]       instruction_in,
    output logic              busy,
    output logic              done,
    output logic              wrap_err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RECV  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [0:CNT_W-1]  MAX_WORDS = CNT_W'(2 ** ADDR_W);
    localparam logic [0:CNT_W-1]  CNT_ONE   = CNT_W'(1);
    localparam logic [0:CNT_W-1]  CNT_ZERO  = CNT_W'(0);
    localparam logic [0:ADDR_W-1] ADDR_ONE  = ADDR_W'(1);
    localparam logic [0:ADDR_W-1] ADDR_TOP  = {ADDR_W{1'b1}};

    state_t            state_r;
    logic [0:ADDR_W-1] addr_r;
    logic [0:CNT_W-1]  rem_r;
    logic [1:0]        byte_idx_r;
    logic [0:31]       word_r;
    logic [0:31]       word_s;
    logic [0:CNT_W-1]  rem_init_s;
    logic [0:ADDR_W-1] addr_inc_s;

    // Handshake ready depends on state only, so it drops immediately on reset.
    assign byte_ready = (state_r == ST_RECV);

    // Word with the incoming byte merged in; first byte lands in bits [0:7].
    always_comb begin
        word_s = word_r;
        case (byte_idx_r)
            2'd0:    word_s[0:7]   = byte_in;
            2'd1:    word_s[8:15]  = byte_in;
            2'd2:    word_s[16:23] = byte_in;
            2'd3:    word_s[24:31] = byte_in;
            default: word_s        = word_r;
        endcase
    end

    // Word count clamped to the buffer depth, and the next address (wraps naturally).
    always_comb begin
        if (word_count > MAX_WORDS) begin
            rem_init_s = MAX_WORDS;
        end else begin
            rem_init_s = word_count;
        end
        addr_inc_s = addr_r + ADDR_ONE;
    end

    // Loader FSM with registered strobes and write port.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r         <= ST_IDLE;
            addr_r          <= '0;
            rem_r           <= '0;
            byte_idx_r      <= 2'd0;
            word_r          <= '0;
            load_en         <= 1'b0;
            instr_load_addr <= '0;
            instruction_in  <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            wrap_err        <= 1'b0;
        end else begin
            load_en <= 1'b0;
            done    <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    // abort alongside start keeps the loader idle
                    if (start && !abort) begin
                        wrap_err <= 1'b0;
                        if (rem_init_s == CNT_ZERO) begin
                            done <= 1'b1;
                        end else begin
                            addr_r     <= base_addr;
                            rem_r      <= rem_init_s;
                            byte_idx_r <= 2'd0;
                            busy       <= 1'b1;
                            state_r    <= ST_RECV;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_RECV: begin
                    // abort beats the 4th-byte transition; partial word dropped
                    if (abort) begin
                        byte_idx_r <= 2'd0;
                        busy       <= 1'b0;
                        state_r    <= ST_IDLE;
                    end else if (byte_valid) begin
                        word_r <= word_s;
                        if (byte_idx_r == 2'd3) begin
                            load_en         <= 1'b1;
                            instr_load_addr <= addr_r;
                            instruction_in  <= word_s;
                            state_r         <= ST_WRITE;
                        end else begin
                            byte_idx_r <= byte_idx_r + 2'd1;
                        end
                    end else begin
                        state_r <= ST_RECV;
                    end
                end
                ST_WRITE: begin
                    // the write strobe for this word is already on the port
                    addr_r     <= addr_inc_s;
                    rem_r      <= rem_r - CNT_ONE;
                    byte_idx_r <= 2'd0;
                    if (addr_r == ADDR_TOP) begin
                        wrap_err <= 1'b1;
                    end else begin
                        wrap_err <= wrap_err;
                    end
                    if (abort) begin
                        busy    <= 1'b0;
                        state_r <= ST_IDLE;
                    end else if (rem_r == CNT_ONE) begin
                        done    <= 1'b1;
                        state_r <= ST_DONE;
                    end else begin
                        state_r <= ST_RECV;
                    end
                end
                ST_DONE: begin
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader: random byte streams and load
// parameters, checked against an address/data list derived from the bytes.
module tb_instr_loader;

    localparam int ADDR_W = 10;
    localparam int CNT_W  = 11;
    localparam int DEPTH  = 1024;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              abort;
    logic [0:ADDR_W-1] base_addr;
    logic [0:CNT_W-1]  word_count;
    logic [0:7]        byte_in;
    logic              byte_valid;
    logic              byte_ready;
    logic              load_en;
    logic [0:ADDR_W-1] instr_load_addr;
    logic [0:31]       instruction_in;
    logic              busy;
    logic              done;
    logic              wrap_err;

    int errors = 0;
    int checks = 0;
    int fed;

    logic [7:0]  all_q[$];   // every byte of the current load, in order
    logic [7:0]  tx_q[$];    // bytes for the next feed call
    int          wr_addr[$];
    logic [31:0] wr_data[$];
    time         wr_t[$];
    time         done_t[$];
    time         acc_t[$];

    instr_loader #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .base_addr(base_addr), .word_count(word_count),
        .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
        .load_en(load_en), .instr_load_addr(instr_load_addr),
        .instruction_in(instruction_in), .busy(busy), .done(done),
        .wrap_err(wrap_err)
    );

    always #5 clk = ~clk;

    // Capture buffer writes and done pulses away from the active edge.
    always @(negedge clk) begin
        if (load_en) begin
            wr_addr.push_back(int'(instr_load_addr));
            wr_data.push_back(instruction_in);
            wr_t.push_back($time);
        end
        if (done) done_t.push_back($time);
    end

    function automatic logic [31:0] exp_word(input int k);
        return {all_q[4*k], all_q[4*k+1], all_q[4*k+2], all_q[4*k+3]};
    endfunction

    task automatic clear_mon();
        wr_addr.delete(); wr_data.delete(); wr_t.delete();
        done_t.delete(); acc_t.delete(); all_q.delete(); tx_q.delete();
    endtask

    task automatic rand_bytes(input int n);
        logic [7:0] b;
        tx_q.delete();
        for (int i = 0; i < n; i++) begin
            b = 8'($urandom_range(0, 255));
            tx_q.push_back(b);
            all_q.push_back(b);
        end
    endtask

    task automatic pulse_start(input int base, input int count);
        base_addr  = ADDR_W'(base);
        word_count = CNT_W'(count);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // mode 0: valid always, 1: valid toggles 1/0, 2: random valid
    task automatic feed(input int mode, input int budget);
        int i;
        int cyc;
        i = 0; cyc = 0;
        while (i < tx_q.size() && cyc < budget) begin
            case (mode)
                0:       byte_valid = 1'b1;
                1:       byte_valid = (cyc % 2 == 0);
                default: byte_valid = ($urandom_range(0, 2) != 0);
            endcase
            byte_in = tx_q[i];
            @(negedge clk);
            if (byte_valid && byte_ready) begin
                acc_t.push_back($time);
                i++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        byte_valid = 1'b0;
        fed = i;
    endtask

    task automatic wait_idle(input int budget, output bit ok, output time t);
        ok = 1'b0; t = 0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (!busy) begin ok = 1'b1; t = $time; break; end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b0; abort = 1'b0; byte_valid = 1'b0;
        byte_in = 8'h00; base_addr = '0; word_count = '0;
        #2;
        checks++; if ({byte_ready, load_en, busy, done, wrap_err} !== 5'b0) begin errors++; $display("FAIL reset_flags: got %b expected 00000", {byte_ready, load_en, busy, done, wrap_err}); end
        checks++; if (instr_load_addr !== '0) begin errors++; $display("FAIL reset_addr: got %0d expected 0", instr_load_addr); end
        checks++; if (instruction_in !== '0) begin errors++; $display("FAIL reset_data: got %h expected 0", instruction_in); end
        repeat (2) @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        checks++; if ({byte_ready, busy} !== 2'b00) begin errors++; $display("FAIL reset_idle: got %b expected 00", {byte_ready, busy}); end
        @(posedge clk); #1;
    endtask

    task automatic test_two_words();
        bit ok; time t_idle;
        clear_mon();
        all_q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h23, 8'h45, 8'h67};
        tx_q = all_q;
        pulse_start(0, 2);
        feed(0, 40);
        wait_idle(30, ok, t_idle);
        checks++; if (fed !== 8) begin errors++; $display("FAIL two_fed: got %0d expected 8", fed); end
        checks++; if (!ok) begin errors++; $display("FAIL two_timeout: got busy expected idle"); end
        checks++; if (wr_addr.size() !== 2) begin errors++; $display("FAIL two_nwr: got %0d expected 2", wr_addr.size()); end
        if (wr_addr.size() == 2) begin
            checks++; if (wr_addr[0] !== 0 || wr_data[0] !== 32'hDEADBEEF) begin errors++; $display("FAIL two_w0: got @%0d=%h expected @0=deadbeef", wr_addr[0], wr_data[0]); end
            checks++; if (wr_addr[1] !== 1 || wr_data[1] !== 32'h01234567) begin errors++; $display("FAIL two_w1: got @%0d=%h expected @1=01234567", wr_addr[1], wr_data[1]); end
            checks++; if (wr_t[0] !== acc_t[3] + 10) begin errors++; $display("FAIL two_latency: got %0t expected %0t", wr_t[0], acc_t[3] + 10); end
            checks++; if (done_t.size() !== 1 || done_t[0] !== wr_t[1] + 10) begin errors++; $display("FAIL two_done: got %0d pulses expected 1 at %0t", done_t.size(), wr_t[1] + 10); end
            if (done_t.size() == 1) begin
                checks++; if (t_idle !== done_t[0] + 10) begin errors++; $display("FAIL two_busy_fall: got %0t expected %0t", t_idle, done_t[0] + 10); end
            end
        end
    endtask

    task automatic test_valid_gaps();
        bit ok; time t_idle; int extra; int base;
        clear_mon();
        base = $urandom_range(0, DEPTH - 2);
        rand_bytes(4);
        pulse_start(base, 1);
        feed(1, 20);
        extra = 0;
        byte_valid = 1'b1; byte_in = 8'h5A;
        repeat (6) begin
            @(negedge clk);
            if (byte_valid && byte_ready) extra++;
            @(posedge clk); #1;
        end
        byte_valid = 1'b0;
        wait_idle(10, ok, t_idle);
        checks++; if (fed !== 4 || extra !== 0) begin errors++; $display("FAIL gaps_accepts: got %0d+%0d expected 4+0", fed, extra); end
        checks++; if (wr_addr.size() !== 1) begin errors++; $display("FAIL gaps_nwr: got %0d expected 1", wr_addr.size()); end
        if (wr_addr.size() == 1) begin
            checks++; if (wr_addr[0] !== base || wr_data[0] !== exp_word(0)) begin errors++; $display("FAIL gaps_word: got @%0d=%h expected @%0d=%h", wr_addr[0], wr_data[0], base, exp_word(0)); end
        end
        checks++; if (done_t.size() !== 1) begin errors++; $display("FAIL gaps_done: got %0d expected 1", done_t.size()); end
    endtask

    task automatic test_wrap();
        bit ok; time t_idle;
        clear_mon();
        rand_bytes(4);
        pulse_start(DEPTH - 1, 2);
        feed(0, 20);
        @(negedge clk); @(posedge clk); #1;
        @(negedge clk);
        checks++; if (wrap_err !== 1'b1) begin errors++; $display("FAIL wrap_set: got %b expected 1", wrap_err); end
        @(posedge clk); #1;
        rand_bytes(4);
        feed(2, 100);
        wait_idle(20, ok, t_idle);
        checks++; if (wr_addr.size() !== 2) begin errors++; $display("FAIL wrap_nwr: got %0d expected 2", wr_addr.size()); end
        if (wr_addr.size() == 2) begin
            checks++; if (wr_addr[0] !== DEPTH - 1 || wr_data[0] !== exp_word(0)) begin errors++; $display("FAIL wrap_w0: got @%0d=%h expected @1023=%h", wr_addr[0], wr_data[0], exp_word(0)); end
            checks++; if (wr_addr[1] !== 0 || wr_data[1] !== exp_word(1)) begin errors++; $display("FAIL wrap_w1: got @%0d=%h expected @0=%h", wr_addr[1], wr_data[1], exp_word(1)); end
        end
        checks++; if (wrap_err !== 1'b1) begin errors++; $display("FAIL wrap_hold: got %b expected 1", wrap_err); end
        clear_mon();
        pulse_start(5, 1);
        @(negedge clk);
        checks++; if (wrap_err !== 1'b0) begin errors++; $display("FAIL wrap_clear: got %b expected 0", wrap_err); end
        @(posedge clk); #1;
        rand_bytes(4);
        feed(0, 20);
        wait_idle(20, ok, t_idle);
        checks++; if (wr_addr.size() !== 1 || wr_data[0] !== exp_word(0) || wr_addr[0] !== 5) begin errors++; $display("FAIL wrap_next: got %0d writes expected 1 @5=%h", wr_addr.size(), exp_word(0)); end
    endtask

    task automatic test_random_loads();
        bit ok; time t_idle; int base; int cnt; int bad; bit exp_wrap;
        for (int it = 0; it < 4; it++) begin
            clear_mon();
            base = (it % 2 == 1) ? $urandom_range(DEPTH - 6, DEPTH - 1) : $urandom_range(0, DEPTH - 1);
            cnt = $urandom_range(1, 6);
            exp_wrap = (base + cnt - 1 >= DEPTH - 1);
            rand_bytes(4 * cnt);
            pulse_start(base, cnt);
            feed(2, 400);
            wait_idle(40, ok, t_idle);
            checks++; if (fed !== 4 * cnt || !ok) begin errors++; $display("FAIL rnd%0d_feed: got %0d bytes ok=%b expected %0d", it, fed, ok, 4 * cnt); end
            checks++; if (wr_addr.size() !== cnt) begin errors++; $display("FAIL rnd%0d_nwr: got %0d expected %0d", it, wr_addr.size(), cnt); end
            bad = 0;
            for (int k = 0; k < wr_addr.size() && k < cnt; k++)
                if (wr_addr[k] !== (base + k) % DEPTH || wr_data[k] !== exp_word(k)) bad++;
            checks++; if (bad !== 0) begin errors++; $display("FAIL rnd%0d_words: got %0d bad words expected 0", it, bad); end
            checks++; if (wrap_err !== exp_wrap || done_t.size() !== 1) begin errors++; $display("FAIL rnd%0d_flags: got wrap=%b done=%0d expected wrap=%b done=1", it, wrap_err, done_t.size(), exp_wrap); end
        end
    endtask

    task automatic test_abort();
        bit ok; time t_idle; int extra;
        // abort after 2 bytes of word 0
        clear_mon();
        rand_bytes(2);
        pulse_start(10, 2);
        feed(0, 20);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        checks++; if ({busy, byte_ready} !== 2'b00) begin errors++; $display("FAIL abort_idle: got %b expected 00", {busy, byte_ready}); end
        @(posedge clk); #1;
        extra = 0; byte_valid = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (byte_valid && byte_ready) extra++;
            @(posedge clk); #1;
        end
        byte_valid = 1'b0;
        checks++; if (wr_addr.size() !== 0 || done_t.size() !== 0 || extra !== 0) begin errors++; $display("FAIL abort_quiet: got wr=%0d done=%0d acc=%0d expected 0/0/0", wr_addr.size(), done_t.size(), extra); end
        clear_mon();
        rand_bytes(4);
        pulse_start(20, 1);
        feed(0, 20);
        wait_idle(20, ok, t_idle);
        checks++; if (wr_addr.size() !== 1 || wr_addr[0] !== 20 || wr_data[0] !== exp_word(0)) begin errors++; $display("FAIL abort_restart: got %0d writes expected 1 @20=%h", wr_addr.size(), exp_word(0)); end
        // abort coinciding with the 4th byte
        clear_mon();
        rand_bytes(3);
        pulse_start(30, 1);
        feed(0, 20);
        byte_valid = 1'b1; byte_in = 8'hC3; abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0; byte_valid = 1'b0;
        repeat (4) @(posedge clk); #1;
        checks++; if (wr_addr.size() !== 0 || done_t.size() !== 0 || busy !== 1'b0) begin errors++; $display("FAIL abort_4th: got wr=%0d done=%0d busy=%b expected 0/0/0", wr_addr.size(), done_t.size(), busy); end
        // abort during the write cycle
        clear_mon();
        rand_bytes(4);
        pulse_start(40, 2);
        feed(0, 20);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        extra = 0; byte_valid = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (byte_valid && byte_ready) extra++;
            @(posedge clk); #1;
        end
        byte_valid = 1'b0;
        checks++; if (wr_addr.size() !== 1 || wr_addr[0] !== 40 || wr_data[0] !== exp_word(0)) begin errors++; $display("FAIL abort_write: got %0d writes expected 1 @40=%h", wr_addr.size(), exp_word(0)); end
        checks++; if (done_t.size() !== 0 || extra !== 0 || busy !== 1'b0) begin errors++; $display("FAIL abort_write_after: got done=%0d acc=%0d busy=%b expected 0/0/0", done_t.size(), extra, busy); end
        // start and abort together while idle
        clear_mon();
        base_addr = ADDR_W'(50); word_count = CNT_W'(1);
        start = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        @(negedge clk);
        checks++; if ({busy, byte_ready, done} !== 3'b000) begin errors++; $display("FAIL start_abort: got %b expected 000", {busy, byte_ready, done}); end
        @(posedge clk); #1;
    endtask

    task automatic test_zero_and_busy_start();
        bit ok; time t_idle; time t0;
        clear_mon();
        pulse_start(77, 0);
        t0 = $time;
        repeat (4) @(posedge clk); #1;
        checks++; if (done_t.size() !== 1 || done_t[0] !== t0 + 4) begin errors++; $display("FAIL zero_done: got %0d pulses expected 1 at %0t", done_t.size(), t0 + 4); end
        checks++; if (wr_addr.size() !== 0 || busy !== 1'b0) begin errors++; $display("FAIL zero_nowrite: got wr=%0d busy=%b expected 0/0", wr_addr.size(), busy); end
        clear_mon();
        rand_bytes(2);
        pulse_start(100, 1);
        feed(0, 20);
        pulse_start(200, 3);
        rand_bytes(2);
        feed(0, 20);
        wait_idle(20, ok, t_idle);
        checks++; if (wr_addr.size() !== 1 || wr_addr[0] !== 100 || wr_data[0] !== exp_word(0)) begin errors++; $display("FAIL busy_start: got %0d writes expected 1 @100=%h", wr_addr.size(), exp_word(0)); end
        checks++; if (done_t.size() !== 1 || !ok) begin errors++; $display("FAIL busy_start_done: got %0d expected 1", done_t.size()); end
    endtask

    task automatic test_clamp();
        bit ok; time t_idle; int bad;
        clear_mon();
        rand_bytes(4 * DEPTH);
        pulse_start(0, 2047);
        feed(0, 6000);
        wait_idle(20, ok, t_idle);
        checks++; if (fed !== 4 * DEPTH || wr_addr.size() !== DEPTH) begin errors++; $display("FAIL clamp_count: got %0d bytes %0d writes expected %0d/%0d", fed, wr_addr.size(), 4 * DEPTH, DEPTH); end
        bad = 0;
        for (int k = 0; k < wr_addr.size() && k < DEPTH; k++)
            if (wr_addr[k] !== k || wr_data[k] !== exp_word(k)) bad++;
        checks++; if (bad !== 0) begin errors++; $display("FAIL clamp_words: got %0d bad words expected 0", bad); end
        checks++; if (done_t.size() !== 1 || wrap_err !== 1'b1 || !ok) begin errors++; $display("FAIL clamp_end: got done=%0d wrap=%b expected 1/1", done_t.size(), wrap_err); end
    endtask

    task automatic test_async_reset();
        clear_mon();
        rand_bytes(4);
        tx_q[0] = 8'hA5;
        all_q[0] = 8'hA5;
        pulse_start(DEPTH - 1, 2);
        feed(0, 20);
        rand_bytes(2);
        feed(0, 20);
        #2;
        rst = 1'b0;
        #1;
        checks++; if ({byte_ready, load_en, busy, done, wrap_err} !== 5'b0) begin errors++; $display("FAIL async_flags: got %b expected 00000", {byte_ready, load_en, busy, done, wrap_err}); end
        checks++; if (instr_load_addr !== '0 || instruction_in !== '0) begin errors++; $display("FAIL async_port: got @%0d=%h expected @0=0", instr_load_addr, instruction_in); end
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b1;
        byte_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checks++; if ({byte_ready, busy} !== 2'b00) begin errors++; $display("FAIL async_idle: got %b expected 00", {byte_ready, busy}); end
        end
        byte_valid = 1'b0;
        checks++; if (wr_addr.size() !== 1) begin errors++; $display("FAIL async_nwr: got %0d expected 1", wr_addr.size()); end
    endtask

    initial begin
        test_reset();
        test_two_words();
        test_valid_gaps();
        test_wrap();
        test_random_loads();
        test_abort();
        test_zero_and_busy_start();
        test_clamp();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
